// File: rtl/mem_boot_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to memory and
// holds the CPU until the image is loaded. Optional checksum output: define LOADER_CHECKSUM_EN.
module mem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] len_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] data_addr,
    output logic [31:0] data_in,
    output logic        wr_en,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum,
    output logic [2:0]  state_dbg
);

    // Highest legal length once the base offset has consumed part of the memory.
    localparam logic [31:0] LIMIT_WORDS = 32'(MEM_WORDS) - (BASE_ADDR >> 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] len_q, len_d;
    logic [12:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_in_q, data_in_d;
    logic        byte_ready_q, byte_ready_d;
    logic        wr_en_q, wr_en_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_take;

    // Byte handshake: a byte moves on a rising edge where byte_valid && byte_ready are both
    // high; byte_ready is registered, and the source holds byte_data until that edge.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        data_addr_d = data_addr_q;
        data_in_d   = data_in_q;
        start_take  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    start_take = 1'b1;
                    if (len_words == 13'd0) begin
                        state_d = S_DONE;
                    end else if ({19'd0, len_words} > LIMIT_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_LOAD;
                    end
                    len_d       = len_words;
                    data_addr_d = BASE_ADDR;
                    word_cnt_d  = 13'd0;
                    byte_cnt_d  = 2'd0;
                end
            end
            S_LOAD: begin
                if (byte_valid && byte_ready_q) begin
                    shift_d    = {shift_q[15:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        data_in_d = {shift_q, byte_data};
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                data_addr_d = data_addr_q + 32'd4;
                word_cnt_d  = word_cnt_q + 13'd1;
                state_d     = (word_cnt_d == len_q) ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are a registered image of the state being entered.
        byte_ready_d = (state_d == S_LOAD);
        wr_en_d      = (state_d == S_WRITE);
        cpu_hold_d   = (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= 13'd0;
            word_cnt_q   <= 13'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            data_addr_q  <= BASE_ADDR;
            data_in_q    <= 32'd0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            data_addr_q  <= data_addr_d;
            data_in_q    <= data_in_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_take) begin
            checksum_d = 32'd0;
        end else if (state_q == S_WRITE) begin
            checksum_d = checksum_q + data_in_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= 32'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

    assign byte_ready = byte_ready_q;
    assign data_addr  = data_addr_q;
    assign data_in    = data_in_q;
    assign wr_en      = wr_en_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule
